// File: rtl/niios_qsys_nios2_oci_pkg.sv
// Shared constants and state encoding for the OCI DCT trace packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package niios_qsys_nios2_oci_pkg;

   localparam int ATOM_W = 3;
   localparam int ATOMS  = 10;
   localparam int DCT_W  = 30;
   localparam int CNT_W  = 4;

   localparam logic [ATOM_W-1:0] END_CODE = 3'b111;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      DRAIN = 2'd1,
      ENDED = 2'd2
   } dct_state_e;

   // Drop an atom into slot pos of an otherwise-zero-above-pos buffer.
   function automatic logic [DCT_W-1:0] place_atom(
      input logic [DCT_W-1:0]  buf_in,
      input logic [ATOM_W-1:0] a,
      input logic [CNT_W-1:0]  pos
   );
      logic [DCT_W-1:0] a_ext;
      a_ext = DCT_W'(a);
      return buf_in | (a_ext << (int'(pos) * ATOM_W));
   endfunction

endpackage

// File: rtl/niios_qsys_nios2_oci_dct_outreg.sv
// Single-entry valid/ready holding register for packed DCT words.
// Latency: word visible the cycle after load.
// Backpressure: holds word stable until word_ready; free when empty or draining this cycle.
module niios_qsys_nios2_oci_dct_outreg
   import niios_qsys_nios2_oci_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [DCT_W-1:0] load_data,
   input  logic [CNT_W-1:0] load_count,
   output logic             free,
   output logic             word_valid,
   input  logic             word_ready,
   output logic [DCT_W-1:0] word_data,
   output logic [CNT_W-1:0] word_count
);

   assign free = !word_valid || word_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_valid <= 1'b0;
         word_data  <= '0;
         word_count <= '0;
      end else if (load) begin
         word_valid <= 1'b1;
         word_data  <= load_data;
         word_count <= load_count;
      end else if (word_ready) begin
         word_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/niios_qsys_nios2_oci_dct_packer.sv
// Packs 3-bit trace atoms into 30-bit DCT words and tracks end-of-test.
// Latency: 1 cycle from the completing accept to word_valid.
// Backpressure: atom_ready drops while a full buffer waits on a held output word.
module niios_qsys_nios2_oci_dct_packer
   import niios_qsys_nios2_oci_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              atom_valid,
   input  logic [ATOM_W-1:0] atom,
   output logic              atom_ready,
   input  logic              flush,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [DCT_W-1:0]  word_data,
   output logic [CNT_W-1:0]  word_count,
   output logic [DCT_W-1:0]  dct_buffer,
   output logic [CNT_W-1:0]  dct_count,
   output logic              test_ending,
   output logic              test_has_ended
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ATOMS);

   dct_state_e       state;
   logic             run;
   logic             out_free;
   logic             full;
   logic             accept;
   logic             is_end;
   logic             close_now;
   logic             load;
   logic [DCT_W-1:0] load_data;
   logic [CNT_W-1:0] load_count;
   logic [DCT_W-1:0] base_buf;
   logic [CNT_W-1:0] base_cnt;
   logic [DCT_W-1:0] acc_buf;
   logic [CNT_W-1:0] acc_cnt;
   logic [DCT_W-1:0] nxt_buf;
   logic [CNT_W-1:0] nxt_cnt;

   // run keeps atom_ready low through reset and the first cycle after it.
   assign full       = (dct_count == FULL_CNT);
   assign atom_ready = run && (state == FILL) && (!full || out_free);
   assign accept     = atom_valid && atom_ready;
   assign is_end     = (atom == END_CODE);

   always_comb begin
      base_buf   = full ? '0 : dct_buffer;
      base_cnt   = full ? '0 : dct_count;
      acc_buf    = dct_buffer;
      acc_cnt    = dct_count;
      if (accept) begin
         acc_buf = place_atom(base_buf, atom, base_cnt);
         acc_cnt = base_cnt + 1'b1;
      end

      close_now = (accept && !full && ((acc_cnt == FULL_CNT) || is_end))
               || (flush && !accept && (dct_count != '0) && (state == FILL))
               || ((state == DRAIN) && (dct_count != '0));

      load       = 1'b0;
      load_data  = acc_buf;
      load_count = acc_cnt;
      nxt_buf    = acc_buf;
      nxt_cnt    = acc_cnt;
      if (out_free) begin
         if (full) begin
            // Hand off the waiting full word; any atom taken now starts the next word.
            load       = 1'b1;
            load_data  = dct_buffer;
            load_count = dct_count;
            nxt_buf    = accept ? acc_buf : '0;
            nxt_cnt    = accept ? acc_cnt : '0;
         end else if (close_now) begin
            load    = 1'b1;
            nxt_buf = '0;
            nxt_cnt = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run            <= 1'b0;
         state          <= FILL;
         dct_buffer     <= '0;
         dct_count      <= '0;
         test_ending    <= 1'b0;
         test_has_ended <= 1'b0;
      end else begin
         run        <= 1'b1;
         dct_buffer <= nxt_buf;
         dct_count  <= nxt_cnt;
         case (state)
            FILL: begin
               if (accept && is_end) begin
                  state       <= DRAIN;
                  test_ending <= 1'b1;
               end
            end
            DRAIN: begin
               // Empty buffer in DRAIN means the held word is the END-bearing one.
               if ((dct_count == '0) && word_valid && word_ready) begin
                  state          <= ENDED;
                  test_has_ended <= 1'b1;
               end
            end
            default: state <= ENDED;
         endcase
      end
   end

   niios_qsys_nios2_oci_dct_outreg u_outreg (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load),
      .load_data  (load_data),
      .load_count (load_count),
      .free       (out_free),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_data  (word_data),
      .word_count (word_count)
   );

endmodule

// File: tb/tb_niios_qsys_nios2_oci_dct_packer.sv
// Directed bench for the DCT packer: table-driven packing/flush rows plus
// hand-written backpressure, end-of-test and mid-word reset sequences.
module tb_niios_qsys_nios2_oci_dct_packer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        atom_valid;
   logic [2:0]  atom;
   logic        atom_ready;
   logic        flush;
   logic        word_valid;
   logic        word_ready;
   logic [29:0] word_data;
   logic [3:0]  word_count;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        test_ending;
   logic        test_has_ended;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [29:0] W1 = 30'o2106543210;
   localparam logic [29:0] W2 = 30'o5432106543;

   always #5 clk = ~clk;

   niios_qsys_nios2_oci_dct_packer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .atom_valid     (atom_valid),
      .atom           (atom),
      .atom_ready     (atom_ready),
      .flush          (flush),
      .word_valid     (word_valid),
      .word_ready     (word_ready),
      .word_data      (word_data),
      .word_count     (word_count),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_ending    (test_ending),
      .test_has_ended (test_has_ended)
   );

   typedef struct {
      logic        av;
      logic [2:0]  a;
      logic        fl;
      logic        ar;
      logic        wv;
      logic [29:0] wd;
      logic [3:0]  wc;
      logic [29:0] db;
      logic [3:0]  dc;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t v(input logic av, input logic [2:0] a, input logic fl,
                              input logic ar, input logic wv, input logic [29:0] wd,
                              input logic [3:0] wc, input logic [29:0] db, input logic [3:0] dc);
      vec_t r;
      r.av = av; r.a = a; r.fl = fl; r.ar = ar; r.wv = wv;
      r.wd = wd; r.wc = wc; r.db = db; r.dc = dc;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_atom_ready"},     32'(atom_ready),     32'd0);
      chk({tag, "_word_valid"},     32'(word_valid),     32'd0);
      chk({tag, "_word_data"},      32'(word_data),      32'd0);
      chk({tag, "_word_count"},     32'(word_count),     32'd0);
      chk({tag, "_dct_buffer"},     32'(dct_buffer),     32'd0);
      chk({tag, "_dct_count"},      32'(dct_count),      32'd0);
      chk({tag, "_test_ending"},    32'(test_ending),    32'd0);
      chk({tag, "_test_has_ended"}, 32'(test_has_ended), 32'd0);
   endtask

   // Offer atoms (got % 7, never the END code) until n are accepted or the budget runs out.
   task automatic feed(input int n, input logic chk_hold, input logic [29:0] hold_exp,
                       output int got);
      got = 0;
      atom_valid = 1'b1;
      for (int c = 0; c < 100 && got < n; c++) begin
         logic take;
         atom = 3'(got % 7);
         #2;
         if (chk_hold && word_valid) chk("hold_data", 32'(word_data), 32'(hold_exp));
         take = atom_ready;
         cyc();
         if (take) got++;
      end
      atom_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach summary, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      int got;

      tbl[0]  = v(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 30'o0, 4'd0, 30'o0,         4'd0);
      tbl[1]  = v(1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 30'o0, 4'd0, 30'o0,         4'd1);
      tbl[2]  = v(1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 30'o0, 4'd0, 30'o10,        4'd2);
      tbl[3]  = v(1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 30'o0, 4'd0, 30'o210,       4'd3);
      tbl[4]  = v(1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 30'o0, 4'd0, 30'o3210,      4'd4);
      tbl[5]  = v(1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 30'o0, 4'd0, 30'o43210,     4'd5);
      tbl[6]  = v(1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 30'o0, 4'd0, 30'o543210,    4'd6);
      tbl[7]  = v(1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 30'o0, 4'd0, 30'o6543210,   4'd7);
      tbl[8]  = v(1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 30'o0, 4'd0, 30'o06543210,  4'd8);
      tbl[9]  = v(1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 30'o0, 4'd0, 30'o106543210, 4'd9);
      tbl[10] = v(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, W1,    4'd10, 30'o0,        4'd0);
      tbl[11] = v(1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 30'o0, 4'd0, 30'o0,         4'd0);
      tbl[12] = v(1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 30'o0, 4'd0, 30'o5,         4'd1);
      tbl[13] = v(1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 30'o0, 4'd0, 30'o25,        4'd2);
      tbl[14] = v(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 30'o0, 4'd0, 30'o625,       4'd3);
      tbl[15] = v(1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 30'o625, 4'd3, 30'o0,       4'd0);
      tbl[16] = v(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 30'o0, 4'd0, 30'o0,         4'd0);
      tbl[17] = v(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 30'o0, 4'd0, 30'o0,         4'd0);

      reset_n = 1'b0; atom_valid = 1'b0; atom = 3'd0; flush = 1'b0; word_ready = 1'b1;
      #2;
      chk_all_zero("reset");
      @(posedge clk); #1;
      reset_n = 1'b1;
      cyc();

      // Full word, flush of a partial word, flush of an empty buffer.
      for (int i = 0; i < 18; i++) begin
         atom_valid = tbl[i].av;
         atom       = tbl[i].a;
         flush      = tbl[i].fl;
         word_ready = 1'b1;
         #2;
         chk($sformatf("tbl%0d_atom_ready", i), 32'(atom_ready), 32'(tbl[i].ar));
         chk($sformatf("tbl%0d_word_valid", i), 32'(word_valid), 32'(tbl[i].wv));
         chk($sformatf("tbl%0d_dct_buffer", i), 32'(dct_buffer), 32'(tbl[i].db));
         chk($sformatf("tbl%0d_dct_count", i),  32'(dct_count),  32'(tbl[i].dc));
         if (tbl[i].wv) begin
            chk($sformatf("tbl%0d_word_data", i),  32'(word_data),  32'(tbl[i].wd));
            chk($sformatf("tbl%0d_word_count", i), 32'(word_count), 32'(tbl[i].wc));
         end
         cyc();
      end
      flush = 1'b0;

      // Twenty atoms against a stalled consumer.
      word_ready = 1'b0;
      feed(20, 1'b1, W1, got);
      chk("stall_accepted", 32'(got), 32'd20);
      atom_valid = 1'b1; atom = 3'd6;
      #2;
      chk("stall_atom_ready", 32'(atom_ready), 32'd0);
      chk("stall_dct_count",  32'(dct_count),  32'd10);
      chk("stall_dct_buffer", 32'(dct_buffer), 32'(W2));
      chk("stall_word_valid", 32'(word_valid), 32'd1);
      chk("stall_word_data",  32'(word_data),  32'(W1));
      chk("stall_word_count", 32'(word_count), 32'd10);
      cyc();
      #2;
      chk("stall2_dct_count", 32'(dct_count), 32'd10);
      chk("stall2_word_data", 32'(word_data), 32'(W1));

      // Release with atom 4 offered in the same cycle as the handshake.
      word_ready = 1'b1; atom = 3'd4;
      #2;
      chk("release_atom_ready", 32'(atom_ready), 32'd1);
      cyc();
      atom_valid = 1'b0;
      #2;
      chk("release_word_valid", 32'(word_valid), 32'd1);
      chk("release_word_data",  32'(word_data),  32'(W2));
      chk("release_word_count", 32'(word_count), 32'd10);
      chk("release_dct_buffer", 32'(dct_buffer), 32'o4);
      chk("release_dct_count",  32'(dct_count),  32'd1);
      cyc();
      flush = 1'b1;
      #2;
      chk("w2_dropped", 32'(word_valid), 32'd0);
      cyc();
      flush = 1'b0;
      #2;
      chk("tail_word_valid", 32'(word_valid), 32'd1);
      chk("tail_word_data",  32'(word_data),  32'o4);
      chk("tail_word_count", 32'(word_count), 32'd1);
      chk("tail_dct_count",  32'(dct_count),  32'd0);
      cyc();

      // End of test: atoms 1, 2, END.
      word_ready = 1'b0; atom_valid = 1'b1;
      atom = 3'd1; #2; cyc();
      atom = 3'd2; #2; cyc();
      atom = 3'd7;
      #2;
      chk("end_atom_ready", 32'(atom_ready), 32'd1);
      cyc();
      atom = 3'd3;
      #2;
      chk("end_test_ending",    32'(test_ending),    32'd1);
      chk("end_atom_ready_off", 32'(atom_ready),     32'd0);
      chk("end_word_valid",     32'(word_valid),     32'd1);
      chk("end_word_data",      32'(word_data),      32'o721);
      chk("end_word_count",     32'(word_count),     32'd3);
      chk("end_dct_count",      32'(dct_count),      32'd0);
      chk("end_has_ended_early", 32'(test_has_ended), 32'd0);
      cyc();
      #2;
      chk("drain_has_ended", 32'(test_has_ended), 32'd0);
      chk("drain_word_held", 32'(word_valid),     32'd1);
      word_ready = 1'b1;
      cyc();
      #2;
      chk("ended_has_ended",  32'(test_has_ended), 32'd1);
      chk("ended_word_valid", 32'(word_valid),     32'd0);
      flush = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #2;
         chk($sformatf("ended%0d_atom_ready", k),  32'(atom_ready),  32'd0);
         chk($sformatf("ended%0d_word_valid", k),  32'(word_valid),  32'd0);
         chk($sformatf("ended%0d_dct_count", k),   32'(dct_count),   32'd0);
         chk($sformatf("ended%0d_test_ending", k), 32'(test_ending), 32'd1);
         cyc();
      end

      // Reset mid-word, then restart at slot 0.
      atom_valid = 1'b0; flush = 1'b0;
      reset_n = 1'b0;
      #2;
      cyc();
      reset_n = 1'b1;
      cyc();
      cyc();
      word_ready = 1'b0;
      feed(16, 1'b0, 30'o0, got);
      chk("mid_accepted", 32'(got), 32'd16);
      #2;
      chk("mid_dct_count",  32'(dct_count),  32'd6);
      chk("mid_dct_buffer", 32'(dct_buffer), 32'o106543);
      chk("mid_word_valid", 32'(word_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      cyc();
      reset_n = 1'b1;
      cyc();
      cyc();
      word_ready = 1'b1; atom_valid = 1'b1; atom = 3'd6;
      #2;
      chk("restart_atom_ready", 32'(atom_ready), 32'd1);
      cyc();
      atom = 3'd5;
      #2;
      chk("restart_dct_buffer", 32'(dct_buffer), 32'o6);
      chk("restart_dct_count",  32'(dct_count),  32'd1);
      cyc();
      atom_valid = 1'b0; flush = 1'b1;
      #2;
      chk("restart2_dct_buffer", 32'(dct_buffer), 32'o56);
      chk("restart2_dct_count",  32'(dct_count),  32'd2);
      cyc();
      flush = 1'b0;
      #2;
      chk("restart_word_valid", 32'(word_valid), 32'd1);
      chk("restart_word_data",  32'(word_data),  32'o56);
      chk("restart_word_count", 32'(word_count), 32'd2);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
